// File: rtl/tpm_pkg.sv
// Shared TPM definitions for the command-parsing front end.
//  - Structure tags accepted in a command header.
//  - Command codes the parser extracts parameters for.
//  - Header response codes reported alongside each parsed command.
//  - Parser state encoding.
package tpm_pkg;

    localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
    localparam logic [15:0] TPM_ST_SESSIONS    = 16'h8002;

    localparam logic [31:0] TPM_CC_HIERARCHY_CONTROL    = 32'h0000_0121;
    localparam logic [31:0] TPM_CC_INCREMENTAL_SELFTEST = 32'h0000_0142;
    localparam logic [31:0] TPM_CC_SELFTEST             = 32'h0000_0143;
    localparam logic [31:0] TPM_CC_STARTUP              = 32'h0000_0144;
    localparam logic [31:0] TPM_CC_SHUTDOWN             = 32'h0000_0145;

    localparam logic [31:0] TPM_RC_SUCCESS      = 32'h0000_0000;
    localparam logic [31:0] TPM_RC_BAD_TAG      = 32'h0000_001E;
    localparam logic [31:0] TPM_RC_COMMAND_SIZE = 32'h0000_0142;
    localparam logic [31:0] TPM_RC_AUTH_MISSING = 32'h0000_0125;

    // Smallest legal command: tag(2) + commandSize(4) + commandCode(4).
    localparam logic [31:0] TPM_HDR_BYTES = 32'd10;

    typedef enum logic [3:0] {
        S_TAG,
        S_SIZE,
        S_CODE,
        S_HANDLE,
        S_AUTHSZ,
        S_AUTH,
        S_PARAM,
        S_DRAIN,
        S_EMIT
    } parser_state_e;

endpackage

// File: rtl/tpm_be_field_shift.sv
// 32-bit big-endian byte accumulator. Each shifted byte enters at the LSB
// end, so after N bytes the low 8*N bits hold the field MSB-first as it
// arrived on the wire. clear_i has priority over shift_i.
// Ports:
//  clock, reset_n  clock and asynchronous active-low reset
//  clear_i         zero the accumulator
//  shift_i         shift byte_i in
//  byte_i          incoming byte
//  field_next_o    value the accumulator holds once byte_i is shifted in;
//                  lets the caller capture a field on its final byte
module tpm_be_field_shift
    import tpm_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] field_next_o
);

    logic [31:0] field_q;
    logic [31:0] field_d;

    assign field_next_o = {field_q[23:0], byte_i};

    always_comb begin
        field_d = field_q;
        if (clear_i) begin
            field_d = '0;
        end else if (shift_i) begin
            field_d = field_next_o;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

endmodule

// File: rtl/tpm_cmd_parser.sv
// TPM command header parser. Consumes the raw command byte stream, checks
// the 10-byte header, extracts command code / locality / parameters and
// presents one parsed command per frame over a valid/ready handshake.
// Frames with header errors are drained to rx_last and still emitted,
// carrying a non-zero hdr_rc.
// Ports:
//  clock, reset_n        clock, asynchronous active-low reset
//  rx_data/valid/last    command byte stream; rx_ready accepts a byte
//  locality_in           transport locality, latched with byte 1
//  cmd_valid/cmd_ready   parsed-command handshake
//  tpm_cc, cmd_param, auth_handle, cmd_size, locality, hdr_rc
//                        parsed command fields, stable while cmd_valid
module tpm_cmd_parser
    import tpm_pkg::*;
#(
    parameter int MAX_CMD_SIZE = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    input  logic [7:0]  locality_in,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] tpm_cc,
    output logic [32:0] cmd_param,
    output logic [31:0] auth_handle,
    output logic [31:0] cmd_size,
    output logic [7:0]  locality,
    output logic [31:0] hdr_rc
);

    localparam int CW = $clog2(MAX_CMD_SIZE) + 1;
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_CMD_SIZE + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [31:0]   MAX_SIZE = 32'(MAX_CMD_SIZE);

    parser_state_e state_q, state_d;
    logic [31:0]   rem_q, rem_d;        // bytes still to come in the current field
    logic [CW-1:0] count_q, count_d;    // accepted bytes in this frame
    logic          done_q, done_d;      // all fields for this code extracted
    logic          rx_ready_q, rx_ready_d;
    logic [15:0]   tag_q, tag_d;
    logic [31:0]   size_q, size_d;
    logic [31:0]   cc_q, cc_d;
    logic [32:0]   param_q, param_d;
    logic [31:0]   auth_q, auth_d;
    logic [7:0]    loc_q, loc_d;
    logic [31:0]   rc_q, rc_d;

    logic          sh_clear;
    logic          sh_shift;
    logic [31:0]   fn;                  // field value including the current byte
    logic          err;
    logic [31:0]   err_rc;

    tpm_be_field_shift u_field (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (sh_clear),
        .shift_i      (sh_shift),
        .byte_i       (rx_data),
        .field_next_o (fn)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        count_d    = count_q;
        done_d     = done_q;
        tag_d      = tag_q;
        size_d     = size_q;
        cc_d       = cc_q;
        param_d    = param_q;
        auth_d     = auth_q;
        loc_d      = loc_q;
        rc_d       = rc_q;
        sh_clear   = 1'b0;
        sh_shift   = 1'b0;
        err        = 1'b0;
        err_rc     = TPM_RC_SUCCESS;

        if (state_q == S_EMIT) begin
            // Handshake returns every field to 0 so a truncated next frame
            // reports unreceived fields as 0.
            if (cmd_ready) begin
                state_d  = S_TAG;
                rem_d    = 32'd2;
                count_d  = '0;
                done_d   = 1'b0;
                tag_d    = '0;
                size_d   = '0;
                cc_d     = '0;
                param_d  = '0;
                auth_d   = '0;
                loc_d    = '0;
                rc_d     = TPM_RC_SUCCESS;
                sh_clear = 1'b1;
            end
        end else if (rx_valid && rx_ready_q) begin
            count_d = (count_q == CNT_SAT) ? count_q : count_q + CNT_ONE;
            if (count_q == '0) begin
                loc_d = locality_in;
            end

            case (state_q)
                S_TAG: begin
                    sh_shift = 1'b1;
                    rem_d    = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        sh_clear = 1'b1;
                        tag_d    = fn[15:0];
                        if (fn[15:0] != TPM_ST_NO_SESSIONS && fn[15:0] != TPM_ST_SESSIONS) begin
                            err    = 1'b1;
                            err_rc = TPM_RC_BAD_TAG;
                        end else begin
                            state_d = S_SIZE;
                            rem_d   = 32'd4;
                        end
                    end
                end
                S_SIZE: begin
                    sh_shift = 1'b1;
                    rem_d    = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        sh_clear = 1'b1;
                        size_d   = fn;
                        if (fn < TPM_HDR_BYTES || fn > MAX_SIZE) begin
                            err    = 1'b1;
                            err_rc = TPM_RC_COMMAND_SIZE;
                        end else begin
                            state_d = S_CODE;
                            rem_d   = 32'd4;
                        end
                    end
                end
                S_CODE: begin
                    sh_shift = 1'b1;
                    rem_d    = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        sh_clear = 1'b1;
                        cc_d     = fn;
                        if (fn == TPM_CC_HIERARCHY_CONTROL && tag_q == TPM_ST_NO_SESSIONS) begin
                            err    = 1'b1;
                            err_rc = TPM_RC_AUTH_MISSING;
                        end else begin
                            case (fn)
                                TPM_CC_STARTUP, TPM_CC_SHUTDOWN: begin
                                    state_d = S_PARAM;
                                    rem_d   = 32'd2;
                                end
                                TPM_CC_SELFTEST: begin
                                    state_d = S_PARAM;
                                    rem_d   = 32'd1;
                                end
                                TPM_CC_HIERARCHY_CONTROL: begin
                                    state_d = S_HANDLE;
                                    rem_d   = 32'd4;
                                end
                                // IncrementalSelfTest and unknown codes: nothing
                                // to extract, the engine handles the body.
                                default: begin
                                    done_d  = 1'b1;
                                    state_d = S_DRAIN;
                                end
                            endcase
                        end
                    end
                end
                S_HANDLE: begin
                    sh_shift = 1'b1;
                    rem_d    = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        sh_clear = 1'b1;
                        auth_d   = fn;
                        state_d  = S_AUTHSZ;
                        rem_d    = 32'd4;
                    end
                end
                S_AUTHSZ: begin
                    sh_shift = 1'b1;
                    rem_d    = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        sh_clear = 1'b1;
                        if (fn == 32'd0) begin
                            state_d = S_PARAM;
                            rem_d   = 32'd5;
                        end else begin
                            state_d = S_AUTH;
                            rem_d   = fn;
                        end
                    end
                end
                S_AUTH: begin
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d = S_PARAM;
                        rem_d   = 32'd5;
                    end
                end
                S_PARAM: begin
                    sh_shift = 1'b1;
                    rem_d    = rem_q - 32'd1;
                    case (cc_q)
                        TPM_CC_STARTUP, TPM_CC_SHUTDOWN: begin
                            if (rem_q == 32'd1) begin
                                param_d = {17'b0, fn[15:0]};
                            end
                        end
                        TPM_CC_SELFTEST: begin
                            param_d = {32'b0, rx_data[0]};
                        end
                        default: begin
                            // HierarchyControl: 4-byte enable then 1-byte state.
                            if (rem_q == 32'd2) begin
                                param_d[32:1] = fn;
                                sh_clear      = 1'b1;
                            end
                            if (rem_q == 32'd1) begin
                                param_d[0] = rx_data[0];
                            end
                        end
                    endcase
                    if (rem_q == 32'd1) begin
                        sh_clear = 1'b1;
                        done_d   = 1'b1;
                        state_d  = S_DRAIN;
                    end
                end
                default: begin
                end
            endcase

            if (err) begin
                rc_d     = err_rc;
                state_d  = S_DRAIN;
                sh_clear = 1'b1;
            end

            // Final byte: a length mismatch or an unfinished extraction is
            // reported only if no earlier header error was latched.
            if (rx_last) begin
                state_d = S_EMIT;
                if (rc_d == TPM_RC_SUCCESS && (!done_d || 32'(count_d) != size_d)) begin
                    rc_d = TPM_RC_COMMAND_SIZE;
                end
            end
        end

        rx_ready_d = (state_d != S_EMIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_TAG;
            rem_q      <= 32'd2;
            count_q    <= '0;
            done_q     <= 1'b0;
            rx_ready_q <= 1'b0;
            tag_q      <= '0;
            size_q     <= '0;
            cc_q       <= '0;
            param_q    <= '0;
            auth_q     <= '0;
            loc_q      <= '0;
            rc_q       <= TPM_RC_SUCCESS;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            count_q    <= count_d;
            done_q     <= done_d;
            rx_ready_q <= rx_ready_d;
            tag_q      <= tag_d;
            size_q     <= size_d;
            cc_q       <= cc_d;
            param_q    <= param_d;
            auth_q     <= auth_d;
            loc_q      <= loc_d;
            rc_q       <= rc_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign cmd_valid   = (state_q == S_EMIT);
    assign tpm_cc      = cc_q;
    assign cmd_param   = param_q;
    assign auth_handle = auth_q;
    assign cmd_size    = size_q;
    assign locality    = loc_q;
    assign hdr_rc      = rc_q;

endmodule

// File: tb/tb_tpm_cmd_parser.sv
// Scoreboard bench for tpm_cmd_parser: each frame pushes its expected
// parsed command when driven; a consumer pops and compares on every emit.
module tb_tpm_cmd_parser;
    import tpm_pkg::*;

    typedef struct {
        logic [31:0] cc;
        logic [32:0] param;
        logic [31:0] auth;
        logic [31:0] size;
        logic [7:0]  loc;
        logic [31:0] rc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_ready;
    logic [7:0]  locality_in = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] tpm_cc;
    logic [32:0] cmd_param;
    logic [31:0] auth_handle;
    logic [31:0] cmd_size;
    logic [7:0]  locality;
    logic [31:0] hdr_rc;

    exp_t       sb[$];
    logic [7:0] fr[$];
    int errors = 0;
    int checks = 0;
    int emits = 0;
    int pushed = 0;
    int hold_cycles = 0;

    tpm_cmd_parser #(.MAX_CMD_SIZE(4096)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .locality_in (locality_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .tpm_cc      (tpm_cc),
        .cmd_param   (cmd_param),
        .auth_handle (auth_handle),
        .cmd_size    (cmd_size),
        .locality    (locality),
        .hdr_rc      (hdr_rc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] cc, input logic [32:0] param,
                                input logic [31:0] auth, input logic [31:0] size,
                                input logic [7:0] loc, input logic [31:0] rc);
        exp_t e;
        e.cc = cc; e.param = param; e.auth = auth; e.size = size; e.loc = loc; e.rc = rc;
        return e;
    endfunction

    // Drive the first nbytes of fr; locality_in is only valid on byte 1.
    task automatic send(input logic [7:0] loc, input int nbytes, input bit with_last);
        int waited;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clock);
            rx_data     = fr[i];
            rx_valid    = 1'b1;
            rx_last     = with_last && (i == nbytes - 1);
            locality_in = (i == 0) ? loc : ~loc;
            waited = 0;
            while (!rx_ready && waited < 50) begin
                @(negedge clock);
                waited++;
            end
            if (!rx_ready) check("rx_ready_timeout", 64'd0, 64'd1);
            @(posedge clock);
        end
        @(negedge clock);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        if (with_last) check("valid_latency", 64'(cmd_valid), 64'd1);
    endtask

    task automatic run_frame(input logic [7:0] loc, input exp_t e);
        sb.push_back(e);
        pushed++;
        send(loc, fr.size(), 1'b1);
    endtask

    task automatic drain_sb();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    // Consumer: compares every cycle cmd_valid is up, honouring hold_cycles.
    initial begin : consumer
        exp_t e;
        forever begin
            @(negedge clock);
            if (cmd_valid && reset_n) begin
                if (sb.size() == 0) begin
                    check("spurious_emit", 64'd1, 64'd0);
                    cmd_ready = 1'b1;
                    @(negedge clock);
                    cmd_ready = 1'b0;
                end else begin
                    e = sb[0];
                    check("tpm_cc", 64'(tpm_cc), 64'(e.cc));
                    check("cmd_param", 64'(cmd_param), 64'(e.param));
                    check("auth_handle", 64'(auth_handle), 64'(e.auth));
                    check("cmd_size", 64'(cmd_size), 64'(e.size));
                    check("locality", 64'(locality), 64'(e.loc));
                    check("hdr_rc", 64'(hdr_rc), 64'(e.rc));
                    check("rx_ready_in_emit", 64'(rx_ready), 64'd0);
                    if (hold_cycles > 0) begin
                        hold_cycles--;
                        cmd_ready = 1'b0;
                    end else begin
                        cmd_ready = 1'b1;
                        @(negedge clock);
                        cmd_ready = 1'b0;
                        void'(sb.pop_front());
                        emits++;
                        $display("txn %0d: cc=%08h param=%09h auth=%08h size=%08h loc=%02h rc=%03h",
                                 emits, e.cc, e.param, e.auth, e.size, e.loc, e.rc);
                        check("valid_drop", 64'(cmd_valid), 64'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_tpm_cc", 64'(tpm_cc), 64'd0);
        check("rst_hdr_rc", 64'(hdr_rc), 64'd0);
        check("rst_cmd_size", 64'(cmd_size), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rx_ready_after_rst", 64'(rx_ready), 64'd1);

        // Startup(CLEAR)
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0C,8'h00,8'h00,8'h01,8'h44,8'h00,8'h01};
        run_frame(8'h03, mk(32'h144, 33'h1, 32'h0, 32'hC, 8'h03, TPM_RC_SUCCESS));

        // HierarchyControl with 9 auth bytes: 10+4+4+9+5 = 32 bytes
        fr = '{8'h80,8'h02,8'h00,8'h00,8'h00,8'h20,8'h00,8'h00,8'h01,8'h21,
               8'h40,8'h00,8'h00,8'h0C, 8'h00,8'h00,8'h00,8'h09,
               8'hA0,8'hA1,8'hA2,8'hA3,8'hA4,8'hA5,8'hA6,8'hA7,8'hA8,
               8'h40,8'h00,8'h00,8'h0B,8'h00};
        run_frame(8'h01, mk(32'h121, {32'h4000000B, 1'b0}, 32'h4000000C, 32'h20, 8'h01, TPM_RC_SUCCESS));

        // Bad tag: drained, only locality survives
        fr = '{8'h80,8'h03,8'h00,8'h00,8'h00,8'h0C,8'h00,8'h00,8'h01,8'h44,8'h00,8'h01};
        run_frame(8'h02, mk(32'h0, 33'h0, 32'h0, 32'h0, 8'h02, TPM_RC_BAD_TAG));

        // rx_last on byte 11 of a 12-byte command
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0C,8'h00,8'h00,8'h01,8'h44,8'h00};
        run_frame(8'h00, mk(32'h144, 33'h0, 32'h0, 32'hC, 8'h00, TPM_RC_COMMAND_SIZE));

        // commandSize 0x2000 above maximum
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h20,8'h00,8'h00,8'h00,8'h01,8'h44,8'h00,8'h01};
        run_frame(8'h00, mk(32'h0, 33'h0, 32'h0, 32'h2000, 8'h00, TPM_RC_COMMAND_SIZE));
        drain_sb();

        // Backpressure: Shutdown held for 5 cycles while SelfTest bytes wait
        hold_cycles = 5;
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0C,8'h00,8'h00,8'h01,8'h45,8'hAB,8'hCD};
        run_frame(8'h04, mk(32'h145, 33'hABCD, 32'h0, 32'hC, 8'h04, TPM_RC_SUCCESS));
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0B,8'h00,8'h00,8'h01,8'h43,8'h01};
        run_frame(8'h01, mk(32'h143, 33'h1, 32'h0, 32'hB, 8'h01, TPM_RC_SUCCESS));

        // HierarchyControl without sessions tag
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h17,8'h00,8'h00,8'h01,8'h21,
               8'h40,8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h12,8'h34,8'h56,8'h78,8'h01};
        run_frame(8'h00, mk(32'h121, 33'h0, 32'h0, 32'h17, 8'h00, TPM_RC_AUTH_MISSING));

        // HierarchyControl with authSize 0
        fr = '{8'h80,8'h02,8'h00,8'h00,8'h00,8'h17,8'h00,8'h00,8'h01,8'h21,
               8'h40,8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h12,8'h34,8'h56,8'h78,8'h01};
        run_frame(8'h03, mk(32'h121, {32'h12345678, 1'b1}, 32'h40000001, 32'h17, 8'h03, TPM_RC_SUCCESS));

        // Frame ends on byte 5, inside commandSize
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00};
        run_frame(8'h00, mk(32'h0, 33'h0, 32'h0, 32'h0, 8'h00, TPM_RC_COMMAND_SIZE));

        // commandSize 9, one below the header length
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h09,8'h00,8'h00,8'h01};
        run_frame(8'h00, mk(32'h0, 33'h0, 32'h0, 32'h9, 8'h00, TPM_RC_COMMAND_SIZE));

        // IncrementalSelfTest, header only
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0A,8'h00,8'h00,8'h01,8'h42};
        run_frame(8'h00, mk(32'h142, 33'h0, 32'h0, 32'hA, 8'h00, TPM_RC_SUCCESS));

        // Unknown code at the maximum legal size
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h10,8'h00,8'h00,8'h00,8'h01,8'h7B};
        for (int i = 0; i < 4086; i++) fr.push_back(8'(i));
        run_frame(8'h02, mk(32'h17B, 33'h0, 32'h0, 32'h1000, 8'h02, TPM_RC_SUCCESS));

        // Two bytes beyond commandSize before rx_last
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0C,8'h00,8'h00,8'h01,8'h44,8'h00,8'h01,8'h55,8'h66};
        run_frame(8'h00, mk(32'h144, 33'h1, 32'h0, 32'hC, 8'h00, TPM_RC_COMMAND_SIZE));
        drain_sb();

        // Reset after byte 6 of a frame
        fr = '{8'h80,8'h01,8'h00,8'h00,8'h00,8'h0C,8'h00,8'h00,8'h01,8'h44,8'h00,8'h01};
        send(8'h05, 6, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("midrst_cmd_size", 64'(cmd_size), 64'd0);
        check("midrst_locality", 64'(locality), 64'd0);
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_ready_back", 64'(rx_ready), 64'd1);
        run_frame(8'h04, mk(32'h144, 33'h1, 32'h0, 32'hC, 8'h04, TPM_RC_SUCCESS));
        drain_sb();

        repeat (5) @(negedge clock);
        check("emit_count", 64'(emits), 64'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
